// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester byte streams, the uart_tx start/data/busy link and
//   the arbiter status outputs into one connection.
//
//   Handshake: a requester's byte moves on a cycle where req_valid[i] and
//   req_ready[i] are both high. The requester holds valid/data/last stable
//   until that cycle and may withdraw req_valid before it (no byte is taken).
//   req_ready is only ever raised for the current grant owner.
//
//   Signals
//     req_valid  NUM_REQ    per-requester byte valid
//     req_data   8*NUM_REQ  byte i at [8*i+7:8*i]
//     req_last   NUM_REQ    byte i closes its packet
//     req_ready  NUM_REQ    one-hot accept pulse
//     grant      NUM_REQ    one-hot current owner, zero when idle
//     tx_start   1          start pulse to uart_tx
//     tx_data    8          byte to uart_tx
//     tx_busy    1          uart_tx busy
//     burst_cut  1          grant forcibly released (burst limit or gap)
//     state_dbg  3          arbiter FSM state for observation
//
//   Modports: slave = arbiter side, master = requesters + uart_tx side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 burst_cut;
    logic [2:0]           state_dbg;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_start, tx_data, burst_cut, state_dbg
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_start, tx_data, burst_cut, state_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx serializer between NUM_REQ byte-stream requesters.
//   Round-robin at packet granularity: the owner keeps the transmitter until
//   it sends a last byte, reaches MAX_BURST bytes, or leaves req_valid low
//   for GAP_TIMEOUT cycles inside a packet. Bytes are paced by tx_busy so at
//   most one byte is in flight per uart frame.
//
//   Ports
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   uart_tx_arbiter_if.slave (requesters, uart_tx link, status)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        ARB     = 3'd0,
        SEND    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [7:0]           byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 last_q, last_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 burst_cut_q, burst_cut_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     owner_next;
    logic                 own_valid;
    logic                 own_last;
    logic [7:0]           own_data;
    logic                 tx_start_c;
    logic [NUM_REQ-1:0]   req_ready_c;
    logic                 do_release;
    logic                 do_cut;

    // Index wrap without a divider: operands never exceed 2*NUM_REQ-2.
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        if (v >= NUM_REQ) begin
            return IDX_W'(v - NUM_REQ);
        end
        return IDX_W'(v);
    endfunction

    assign own_valid  = bus.req_valid[owner_q];
    assign own_last   = bus.req_last[owner_q];
    assign own_data   = bus.req_data[{owner_q, 3'b000} +: 8];
    assign owner_next = wrap_idx(int'(owner_q) + 1);

    // First valid requester at or above the rr pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && bus.req_valid[wrap_idx(int'(rr_q) + k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(int'(rr_q) + k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_d      = last_q;
        tx_data_d   = tx_data_q;
        burst_cut_d = 1'b0;
        tx_start_c  = 1'b0;
        req_ready_c = '0;
        do_release  = 1'b0;
        do_cut      = 1'b0;

        case (state_q)
            ARB: begin
                if (!bus.tx_busy && pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    state_d           = SEND;
                end
            end
            SEND: begin
                if (own_valid) begin
                    // Guard keeps tx_start off a busy transmitter; the state
                    // simply holds until the line is free.
                    if (!bus.tx_busy) begin
                        tx_start_c           = 1'b1;
                        req_ready_c[owner_q] = 1'b1;
                        tx_data_d            = own_data;
                        last_d               = own_last;
                        byte_cnt_d           = byte_cnt_q + 8'd1;
                        state_d              = WAIT_HI;
                    end
                end else begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (last_q || byte_cnt_q == 8'(MAX_BURST)) begin
                        do_release = 1'b1;
                        // A last byte landing exactly on the burst limit is
                        // an ordinary packet end, not a cut.
                        do_cut     = !last_q;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            GAP: begin
                if (own_valid) begin
                    gap_cnt_d = '0;
                    state_d   = SEND;
                end else if (gap_cnt_q == GAP_W'(GAP_TIMEOUT - 1)) begin
                    do_release = 1'b1;
                    do_cut     = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase

        if (do_release) begin
            grant_d     = '0;
            rr_d        = owner_next;
            byte_cnt_d  = '0;
            gap_cnt_d   = '0;
            burst_cut_d = do_cut;
            state_d     = ARB;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_q        <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            last_q      <= 1'b0;
            tx_data_q   <= '0;
            burst_cut_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_q      <= last_d;
            tx_data_q   <= tx_data_d;
            burst_cut_q <= burst_cut_d;
        end
    end

    // The byte is presented straight from the requester on the start cycle
    // and from the holding register for the rest of the frame.
    assign bus.tx_start  = tx_start_c;
    assign bus.tx_data   = tx_start_c ? own_data : tx_data_q;
    assign bus.req_ready = req_ready_c;
    assign bus.grant     = grant_q;
    assign bus.burst_cut = burst_cut_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with NUM_REQ=4, MAX_BURST=4,
//   GAP_TIMEOUT=8 and a small uart_tx busy model.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM   = 4;
    localparam int MAXB  = 4;
    localparam int GAPT  = 8;
    localparam int FRAME = 6;

    localparam logic [2:0] S_ARB     = 3'd0;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM),
        .MAX_BURST(MAXB),
        .GAP_TIMEOUT(GAPT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cut_cnt   = 0;
    int ready_cnt = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [8:0] src_q[NUM][$];
    logic [NUM-1:0] en = '1;
    bit rand_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [NUM-1:0] g);
        for (int i = 0; i < NUM; i++) begin
            if (g[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    // ---------------- uart_tx model ----------------
    int busy_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tx_busy <= 1'b0;
            busy_cnt    <= 0;
        end else if (bus.tx_start) begin
            bus.tx_busy <= 1'b1;
            busy_cnt    <= FRAME - 1;
            got_q.push_back({idx_of(bus.grant), bus.tx_data});
        end else if (bus.tx_busy) begin
            if (busy_cnt == 0) bus.tx_busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    // ---------------- protocol monitor ----------------
    logic [7:0] prev_data  = '0;
    logic       prev_busy  = 1'b0;
    logic       prev_start = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
            check("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            check("ready_owner", 32'(bus.req_ready & ~bus.grant), 32'd0);
            check("ready_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
            check("start_busy", 32'(bus.tx_start & bus.tx_busy), 32'd0);
            if ((prev_busy || prev_start) && bus.tx_busy)
                check("data_stable", 32'(bus.tx_data), 32'(prev_data));
            if (bus.burst_cut) cut_cnt++;
            ready_cnt += $countones(bus.req_ready);
        end
        prev_busy  = bus.tx_busy;
        prev_start = bus.tx_start;
        prev_data  = bus.tx_data;
    end

    // ---------------- requester driver ----------------
    initial begin
        logic [NUM-1:0]   hs;
        logic [NUM-1:0]   v;
        logic [NUM-1:0]   l;
        logic [8*NUM-1:0] d;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            hs = rst ? '0 : (bus.req_valid & bus.req_ready);
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            if (rand_en) en = NUM'($urandom_range(0, (1 << NUM) - 1));
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < NUM; i++) begin
                if (en[i] && src_q[i].size() > 0) begin
                    v[i]         = 1'b1;
                    l[i]         = src_q[i][0][8];
                    d[8*i +: 8]  = src_q[i][0][7:0];
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
        end
    end

    task automatic load(input int r, input int n, input int base, input bit last_end);
        for (int k = 0; k < n; k++)
            src_q[r].push_back({(last_end && k == n - 1), 8'(base + k)});
    endtask

    task automatic expect_pkt(input int r, input int n, input int base);
        for (int k = 0; k < n; k++)
            exp_q.push_back({2'(r), 8'(base + k)});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  c;
        bit  idle;
        c = 0;
        idle = 1'b0;
        while (!idle && c < budget) begin
            @(negedge clk);
            c++;
            idle = (bus.req_valid == '0) && (bus.state_dbg == S_ARB) && !bus.tx_busy;
            for (int i = 0; i < NUM; i++) if (src_q[i].size() > 0) idle = 1'b0;
        end
        check({name, "_idle_timeout"}, 32'(idle), 32'd1);
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.state_dbg != s && c < budget);
        check({name, "_state_timeout"}, 32'(bus.state_dbg == s), 32'd1);
    endtask

    task automatic compare_sb(input string name);
        int n;
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({name, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] mask;
        int         len;
        logic [7:0] order;   // owner sequence, 2 bits each, first owner in [1:0]
        int         npk;
        int         cuts;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int c0;
        int r0;
        int n;
        int sum;
        tbl[0] = '{4'b1110, 2, 8'b00_11_10_01, 3, 0};  // rr=1: 1,2,3
        tbl[1] = '{4'b1111, 1, 8'b11_10_01_00, 4, 0};  // rr=0: 0,1,2,3
        tbl[2] = '{4'b0101, 3, 8'b00_00_10_00, 2, 0};  // rr=0: 0,2
        tbl[3] = '{4'b0011, 2, 8'b00_00_01_00, 2, 0};  // rr=3: 0,1
        tbl[4] = '{4'b1001, 1, 8'b00_00_00_11, 2, 0};  // rr=2: 3,0
        tbl[5] = '{4'b1111, 4, 8'b00_11_10_01, 4, 0};  // rr=1: 1,2,3,0, last on byte 4
        tbl[6] = '{4'b0100, 2, 8'b00_00_00_10, 1, 0};  // rr=1: 2

        // ---- reset state ----
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_start", 32'(bus.tx_start), 32'd0);
        check("rst_cut", 32'(bus.burst_cut), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'(S_ARB));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- reset in the middle of a frame ----
        load(0, 1, 8'h11, 1'b1);
        wait_state("midrst", S_WAIT_LO, 100);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_grant", 32'(bus.grant), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_start", 32'(bus.tx_start), 32'd0);
        check("midrst_state", 32'(bus.state_dbg), 32'(S_ARB));
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        repeat (30) @(negedge clk);
        check("midrst_no_resend", 32'(got_q.size()), 32'd0);
        check("midrst_idle_state", 32'(bus.state_dbg), 32'(S_ARB));

        // ---- single requester, two-byte packet ----
        r0 = ready_cnt;
        src_q[0].push_back({1'b0, 8'hA5});
        src_q[0].push_back({1'b1, 8'h3C});
        exp_q.push_back({2'd0, 8'hA5});
        exp_q.push_back({2'd0, 8'h3C});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant == '0 && n < 50);
        check("single_grant", 32'(bus.grant), 32'b0001);
        wait_idle("single", 500);
        check("single_grant_after", 32'(bus.grant), 32'd0);
        check("single_ready_cnt", 32'(ready_cnt - r0), 32'd2);
        compare_sb("single");

        // ---- contention rounds from the table ----
        for (int row = 0; row < 7; row++) begin
            c0 = cut_cnt;
            for (int r = 0; r < NUM; r++)
                if (tbl[row].mask[r]) load(r, tbl[row].len, row * 16 + r * 4, 1'b1);
            for (int p = 0; p < tbl[row].npk; p++) begin
                n = int'(tbl[row].order[2*p +: 2]);
                expect_pkt(n, tbl[row].len, row * 16 + n * 4);
            end
            wait_idle("table", 2000);
            check("table_cuts", 32'(cut_cnt - c0), 32'(tbl[row].cuts));
            check("table_grant_idle", 32'(bus.grant), 32'd0);
            compare_sb("table");
        end

        // ---- burst limit: req0 6 bytes, req2 waiting (rr=3) ----
        c0 = cut_cnt;
        load(0, 6, 8'hC0, 1'b1);
        load(2, 1, 8'hD0, 1'b1);
        expect_pkt(0, 4, 8'hC0);
        expect_pkt(2, 1, 8'hD0);
        expect_pkt(0, 2, 8'hC4);
        wait_idle("burst", 2000);
        check("burst_cuts", 32'(cut_cnt - c0), 32'd1);
        compare_sb("burst");

        // ---- gap timeout: req1 one byte without last (rr=1) ----
        c0 = cut_cnt;
        load(1, 1, 8'h5A, 1'b0);
        expect_pkt(1, 1, 8'h5A);
        wait_state("gap", S_GAP, 200);
        check("gap_grant_hold", 32'(bus.grant), 32'b0010);
        load(2, 1, 8'h6B, 1'b1);
        expect_pkt(2, 1, 8'h6B);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant != '0 && n < 50);
        check("gap_release_cycles", 32'(n), 32'(GAPT));
        check("gap_cut_pulse", 32'(bus.burst_cut), 32'd1);
        wait_idle("gap", 1000);
        check("gap_cuts", 32'(cut_cnt - c0), 32'd1);
        compare_sb("gap");

        // ---- random valid toggling, protocol monitor active ----
        sum = 0;
        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(1, 6);
            load($urandom_range(0, NUM - 1), n, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
            sum += n;
        end
        rand_en = 1'b1;
        repeat (400) @(negedge clk);
        rand_en = 1'b0;
        en = '1;
        wait_idle("random", 5000);
        check("random_bytes", 32'(got_q.size()), 32'(sum));
        got_q.delete();
        exp_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
